// File: rtl/nn_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nn_pkg : shared state encoding, clog2 helper and default layer widths
// Rev 1.0
// ---------------------------------------------------------------------------
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int NN_DW   = 8;
  localparam int NN_FRAC = 6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_quant.sv
`default_nettype none
// ---------------------------------------------------------------------------
// neuron_quant : round half-up, rectify (NEURON_RELU_EN) and saturate to DW bits
// Rev 1.0
// ---------------------------------------------------------------------------
module neuron_quant
  import nn_pkg::*;
#(
  parameter int DW    = NN_DW,
  parameter int FRAC  = NN_FRAC,
  parameter int ACC_W = 2 * NN_DW + 4
) (
  input  logic [ACC_W-1:0] acc,
  output logic [DW-1:0]    q
);

  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] r;

  // One extra bit keeps the rounding add from overflowing
  assign ext = {acc[ACC_W-1], acc};

  generate
    if (FRAC > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC - 1);
      assign rnd = ext + HALF;
    end else begin : g_no_round
      assign rnd = ext;
    end
  endgenerate

  assign r = rnd >>> FRAC;

  always_comb begin
    q = r[DW-1:0];
`ifdef NEURON_RELU_EN
    if (r[ACC_W])
      q = '0;
    else if (r > MAX_V)
      q = MAX_V[DW-1:0];
`else
    if (r > MAX_V)
      q = MAX_V[DW-1:0];
    else if (r < MIN_V)
      q = MIN_V[DW-1:0];
`endif
  end

endmodule
`default_nettype wire

// File: rtl/neuron_mac_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// neuron_mac_seq : time-multiplexed neuron, one MAC per cycle, ready/valid I/O
// Output rectification selected by NEURON_RELU_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int                     N_IN  = 15,
  parameter int                     DW    = NN_DW,
  parameter int                     FRAC  = NN_FRAC,
  parameter logic [N_IN*DW-1:0]     W_VEC = '0,
  parameter logic signed [2*DW-1:0] BIAS  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*DW-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data
);

  localparam int ACC_W = 2 * DW + clog2(N_IN + 1);
  localparam int IDX_W = (N_IN > 1) ? clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IN - 1);

  state_t                  state;
  state_t                  state_next;
  logic [N_IN*DW-1:0]      act_vec;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [IDX_W-1:0]        idx;
  logic signed [DW-1:0]    act_sel;
  logic signed [DW-1:0]    w_sel;
  logic signed [2*DW-1:0]  prod;
  logic [DW-1:0]           quant;
  logic                    accept;
  logic                    last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST);

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (last) state_next = OUT;
      OUT:     if (out_ready) state_next = in_valid ? MAC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == OUT) && out_ready);
    out_valid = (state == OUT);
  end

  // Single shared multiplier: operands picked from the captured vector by idx
  always_comb begin
    act_sel = '0;
    w_sel   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx == IDX_W'(i)) begin
        act_sel = act_vec[i*DW +: DW];
        w_sel   = W_VEC[i*DW +: DW];
      end
    end
  end

  assign prod    = (2*DW)'(act_sel) * (2*DW)'(w_sel);
  assign acc_sum = acc + ACC_W'(prod);

  neuron_quant #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_quant (
    .acc (acc_sum),
    .q   (quant)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      act_vec  <= '0;
      acc      <= '0;
      idx      <= '0;
      out_data <= '0;
    end else if (accept) begin
      act_vec <= in_data;
      acc     <= ACC_W'(BIAS);
      idx     <= '0;
    end else if (state == MAC) begin
      acc <= acc_sum;
      idx <= idx + IDX_W'(1);
      if (last)
        out_data <= quant;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_neuron_mac_seq : scoreboard bench for two neuron_mac_seq configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_neuron_mac_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv_a, iv_b, ir_a, ir_b, ov_a, ov_b, ordy;
  logic [23:0] din;
  logic [7:0]  od_a, od_b;

  typedef struct {
    int data;
    int due;
    int inst;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   seen     = 1'b0;
  logic       m_ov, m_ir;
  logic [7:0] m_od;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: three inputs, all weights 64, no bias
  neuron_mac_seq #(
    .N_IN  (3),
    .DW    (8),
    .FRAC  (6),
    .W_VEC (24'h404040),
    .BIAS  (16'sd0)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv_a),
    .in_ready  (ir_a),
    .in_data   (din),
    .out_valid (ov_a),
    .out_ready (ordy),
    .out_data  (od_a)
  );

  // Instance B: one input, weight 32, bias -64
  neuron_mac_seq #(
    .N_IN  (1),
    .DW    (8),
    .FRAC  (6),
    .W_VEC (8'h20),
    .BIAS  (-16'sd64)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv_b),
    .in_ready  (ir_b),
    .in_data   (din[7:0]),
    .out_valid (ov_b),
    .out_ready (ordy),
    .out_data  (od_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int bias, input int w0, input int w1, input int w2,
                               input int a0, input int a1, input int a2);
    int acc;
    int r;
    acc = bias + a0 * w0 + a1 * w1 + a2 * w2;
    r   = (acc + 32) >>> 6;
`ifdef NEURON_RELU_EN
    if (r < 0) r = 0;
    if (r > 127) r = 127;
`else
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (sb.size() > 0) begin
        m_ov = (sb[0].inst == 1) ? ov_b : ov_a;
        m_ir = (sb[0].inst == 1) ? ir_b : ir_a;
        m_od = (sb[0].inst == 1) ? od_b : od_a;
        if (m_ov) begin
          if (!seen) begin
            check("latency", cyc, sb[0].due);
            seen = 1'b1;
          end
          check("out_data", $signed(m_od), sb[0].data);
          if (!ordy) begin
            check("in_ready_stall", int'(m_ir), 0);
          end else begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end else if (seen) begin
          check("valid_held", int'(m_ov), 1);
        end
      end else begin
        check("idle_valid", int'(ov_a | ov_b), 0);
      end
    end
  end

  task automatic send(input int inst, input int a0, input int a1, input int a2, input bit push);
    bit   got;
    exp_t e;
    got = 1'b0;
    din = {a2[7:0], a1[7:0], a0[7:0]};
    if (inst == 0) iv_a = 1'b1;
    else iv_b = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((inst == 0 && ir_a) || (inst == 1 && ir_b)) begin
        got = 1'b1;
        break;
      end
    end
    check("handshake", int'(got), 1);
    if (got && push) begin
      e.inst = inst;
      e.due  = cyc + 1 + ((inst == 0) ? 3 : 1);
      e.data = (inst == 0) ? model(0, 64, 64, 64, a0, a1, a2)
                           : model(-64, 32, 0, 0, a0, 0, 0);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
    din  = 24'($urandom);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && sb.size() > 0; k++) @(posedge clk);
    check("drain", sb.size(), 0);
    #1;
  endtask

  initial begin
    bit got;
    reset = 1'b0;
    iv_a  = 1'b0;
    iv_b  = 1'b0;
    ordy  = 1'b1;
    din   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_ov_a", int'(ov_a), 0);
    check("rst_od_a", int'(od_a), 0);
    check("rst_ir_a", int'(ir_a), 1);
    check("rst_ov_b", int'(ov_b), 0);
    check("rst_ir_b", int'(ir_b), 1);
    @(posedge clk);
    #1;

    // Basic, rounding, saturation and negative patterns on instance A
    send(0, 10, 20, 30, 1);      wait_drain();
    send(0, 1, 0, 0, 1);         wait_drain();
    send(0, 127, 127, 127, 1);   wait_drain();
    send(0, 100, 28, 0, 1);      wait_drain();
    send(0, -128, -128, -128, 1); wait_drain();
    send(0, -128, -1, 0, 1);     wait_drain();
    send(0, -10, 0, 0, 1);       wait_drain();

    // Instance B: bias and half-up rounding boundaries
    send(1, 0, 0, 0, 1);
    send(1, 3, 0, 0, 1);
    send(1, 1, 0, 0, 1);
    send(1, 2, 0, 0, 1);
    send(1, 127, 0, 0, 1);
    send(1, -128, 0, 0, 1);
    wait_drain();

    // Back-to-back random vectors with out_ready held high
    for (int i = 0; i < 6; i++)
      send(0, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
           int'($urandom_range(255)) - 128, 1);
    wait_drain();

    // Backpressure: stall 5 cycles, then release together with a new vector
    ordy = 1'b0;
    send(0, 5, 6, 7, 1);
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ov_a) begin
        got = 1'b1;
        break;
      end
    end
    check("bp_valid", int'(got), 1);
    repeat (5) @(posedge clk);
    #1 ordy = 1'b1;
    send(0, 7, 8, 9, 1);
    wait_drain();

    // Reset on the second MAC cycle aborts the vector
    send(0, 1, 2, 3, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_ov", int'(ov_a), 0);
    check("abort_od", int'(od_a), 0);
    check("abort_ir", int'(ir_a), 1);
    @(posedge clk);
    #1;
    send(0, 2, 3, 4, 1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Parametrised, time-multiplexed fully-connected neuron for the ECG network layers. It accepts one vector of N_IN signed activations through a valid/ready handshake and runs one signed multiply-accumulate per cycle against compile-time weights and bias. It then rounds, rectifies and saturates the accumulator to a signed DW-bit activation and presents it through an output valid/ready handshake. It is the successor of the fully-parallel per-node neurons: one multiplier instead of N_IN, with backpressure so nodes can be chained or shared.

## Interface
- N_IN, 15: number of input activations/weights (≥1)
- DW, 8: activation and weight width, two's complement
- FRAC, 6: fractional bits dropped from the accumulator before output
- W_VEC, all 0: N_IN*DW flat signed weights; weight i is in bits [i*DW +: DW]
- BIAS, 0: 2*DW-bit signed bias, same scale as a product
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  N_IN*DW  activations; activation i is in bits [i*DW +: DW]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  DW  signed result activation

## Operation
- ACC_W = 2*DW + clog2(N_IN+1). Products are a full 2*DW-bit signed DW×DW multiply, sign-extended to ACC_W. BIAS is sign-extended to ACC_W.
- States:
  - IDLE: in_ready=1. A handshake registers in_data, sets acc=BIAS and idx=0, and moves to MAC.
  - MAC: each cycle acc += act[idx]*W[idx]; idx++. After idx=N_IN-1, the quantised result is registered into out_data and the state moves to OUT.
  - OUT: out_valid=1, out_data held stable. When out_ready=1, the result is released. If in_valid=1 in the same cycle, the new vector is captured and the state goes straight to MAC; otherwise it returns to IDLE.
- in_ready = (state==IDLE) || (state==OUT && out_ready). It is combinational from out_ready only.
- in_data is ignored outside an in_ready cycle. Vectors are never dropped or duplicated.
- Quantisation, in order:
  1. r = (acc + 2^(FRAC-1)) >>> FRAC. This rounds half-up, arithmetic shift, computed at ACC_W+1 bits so it cannot overflow.
  2. Rectify/saturate per Configuration.
  3. Saturation is applied after rounding, so a rounded value of 2^(DW-1) yields 2^(DW-1)-1, never a wrap.
- FRAC=0: no rounding term is added.
- Reset (reset=0 at a clock edge): state=IDLE, acc=0, idx=0, out_valid=0, out_data=0, in_ready=1 the following cycle. Reset mid-MAC or mid-OUT aborts the vector with no output.

## Timing
- A handshake at edge t leads to MACs on edges t+1..t+N_IN. out_valid rises after edge t+N_IN, so latency is N_IN+1 cycles.
- Throughput: one vector per N_IN+1 cycles when out_ready is held at 1 and in_valid is continuous.
- out_valid and out_data are registered, with no combinational path from inputs.
- With out_ready=0, the block stalls in OUT indefinitely and in_ready=0.

## Configuration
- NEURON_RELU_EN defined: negative r gives 0; r > 2^(DW-1)-1 gives 2^(DW-1)-1. Output range is [0, 127] for DW=8.
- NEURON_RELU_EN undefined: signed saturation to [-2^(DW-1), 2^(DW-1)-1], i.e. [-128, 127] for DW=8. Use this for the final logits layer.

## Structure
- Package nn_pkg holds:
  - the state enum (IDLE, MAC, OUT)
  - the clog2 helper function
  - default DW/FRAC localparams shared by all layer nodes
- Sub-module neuron_quant: combinational round, rectify and saturate, parameters DW, FRAC, ACC_W, and the NEURON_RELU_EN handling. It is reused by future parallel nodes.
- One shared multiplier. Weights are selected from W_VEC by idx; no RAM.

## Test plan
- Basic result: N_IN=3, FRAC=6, W={64,64,64}, BIAS=0, in={10,20,30}. Requires out_data=60, with out_valid rising 4 cycles after the handshake.
- Rounding: N_IN=1, W=32, in=1 (acc=32) requires 1. Also W=31, in=1 requires 0.
- Saturation: N_IN=3, W all 127, in all 127 (acc=48387) requires 127. Without the macro, in all -128 with W=127 requires -128.
- Negative result: N_IN=1, W=64, in=-10 requires 0 with NEURON_RELU_EN and -10 without it. Also BIAS=-64, in=0 requires 0 with the macro and -1 without it.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles. out_valid and out_data must stay stable and in_ready=0. Then raise out_ready with in_valid=1: the next vector is accepted in the same cycle and its result follows N_IN+1 cycles later.
- Reset mid-MAC: drive reset=0 on the 2nd MAC cycle. The next cycle must show out_valid=0, out_data=0, in_ready=1, and the following vector must produce a correct result, not contaminated by the aborted accumulator.
